// File: rtl/instr_seq_pkg.sv
// Shared types and instruction field layout for the fetch/decode/dispatch sequencer.
// No logic, so no latency.
// No flow control.
package instr_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 8;
    localparam int SRC_MSB = 7;
    localparam int SRC_LSB = 4;
    localparam int RSV_MSB = 3;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_FAULT
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Counts done-less WAIT cycles and flags the TIMEOUT-th one.
// expire is combinational from the count and en, and feeds only the owner's state register.
// No flow control; clr has priority over en.
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt already holds TIMEOUT-1 misses, so this cycle is the TIMEOUT-th.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetches one instruction per slot, dispatches a start pulse to the addressed unit, and waits for its done.
// Run to op_start takes 3 cycles; the minimum instruction period is 4 cycles.
// Stalls in WAIT until the selected unit's done arrives; traps halt, illegal opcode and watchdog expiry.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int              AW       = 8,
    parameter int              NUM_OPS  = 8,
    parameter int              TIMEOUT  = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic [AW-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [NUM_OPS-1:0]   op_start,
    input  logic [NUM_OPS-1:0]   op_done,
    input  logic                 pc_inc,
    output logic [3:0]           dst_sel,
    output logic [3:0]           src_sel,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault
);

    state_t               state;
    logic [AW-1:0]        pc;
    logic [INSTR_W-1:0]   ir;
    logic [3:0]           rd_opc;
    logic [NUM_OPS-1:0]   rd_sel;
    logic [NUM_OPS-1:0]   cur_sel;
    logic                 done_hit;
    logic                 wd_expire;
    logic                 unused_rsvd;

    assign rd_opc   = opcode_of(imem_rdata);
    assign rd_sel   = NUM_OPS'(1) << rd_opc;
    assign cur_sel  = NUM_OPS'(1) << opcode_of(ir);
    // Other units' done bits are masked off so a stray done cannot retire this instruction.
    assign done_hit = (state == S_WAIT) && |(op_done & cur_sel);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == S_ISSUE),
        .en     ((state == S_WAIT) && !done_hit),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            op_start <= '0;
        end else begin
            op_start <= '0;
            if (pc_inc && (state != S_HALT) && (state != S_FAULT)) begin
                pc <= pc + AW'(1);
            end
            case (state)
                S_IDLE:   if (run) state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir <= imem_rdata;
                    if (rd_opc == OP_HALT) begin
                        state <= S_HALT;
                    end else if (int'(rd_opc) >= NUM_OPS) begin
                        state <= S_FAULT;
                    end else begin
                        op_start <= rd_sel;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE:  state <= S_WAIT;
                S_WAIT: begin
                    if (done_hit) begin
                        state <= run ? S_FETCH : S_IDLE;
                    end else if (wd_expire) begin
                        state <= S_FAULT;
                    end
                end
                S_HALT:   state <= S_HALT;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = pc;
    assign dst_sel     = ir[DST_MSB:DST_LSB];
    assign src_sel     = ir[SRC_MSB:SRC_LSB];
    assign busy        = !(state inside {S_IDLE, S_HALT, S_FAULT});
    assign halted      = (state == S_HALT);
    assign fault       = (state == S_FAULT);
    assign unused_rsvd = ^ir[RSV_MSB:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written corner sequences,
// and randomized programs checked against a transaction-level timing/PC model.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  op_start;
    logic [7:0]  op_done;
    logic        pc_inc;
    logic [3:0]  dst_sel;
    logic [3:0]  src_sel;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [15:0] rom [256];

    int n_chk  = 0;
    int n_pass = 0;

    instr_sequencer #(
        .AW       (8),
        .NUM_OPS  (8),
        .TIMEOUT  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .op_start   (op_start),
        .op_done    (op_done),
        .pc_inc     (pc_inc),
        .dst_sel    (dst_sel),
        .src_sel    (src_sel),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the address is presented.
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  start;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic        hlt;
        logic        flt;
        logic        bsy;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; pc_inc = 1'b0; op_done = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random program, random unit latency / pc_inc count / stray done bits.
    task automatic run_episode(input int n_instr);
        int pc_m, opc, d, ninc, gap, r, wait_n;
        logic [15:0] ins;
        logic [7:0]  tgt;
        logic        quiet, ended;
        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 19);
            if (r < 17)       opc = r % 8;
            else if (r == 17) opc = 9;
            else if (r == 18) opc = 12;
            else              opc = 15;
            rom[a] = {4'(opc), 12'($urandom)};
        end
        do_reset();
        run = 1'b1;
        pc_m = 0; gap = 3; ended = 1'b0;
        for (int k = 0; k < n_instr && !ended; k++) begin
            quiet = 1'b1;
            for (int g = 1; g <= gap; g++) begin
                @(negedge clk);
                pc_inc = 1'b0;
                if (g < gap && (op_start != 0 || halted || fault)) quiet = 1'b0;
                op_done = 8'($urandom);
            end
            ins = rom[pc_m];
            opc = int'(ins[15:12]);
            chk("ep_quiet_gap", 32'(quiet), 32'd1);
            chk("ep_imem_addr", 32'(imem_addr), 32'(pc_m));
            if (opc == 15) begin
                chk("ep_halted", {halted, busy, |op_start}, 3'b100);
                ended = 1'b1;
            end else if (opc >= 8) begin
                chk("ep_illegal_fault", {fault, busy, |op_start}, 3'b100);
                ended = 1'b1;
            end else begin
                tgt = 8'(1 << opc);
                chk("ep_op_start", 32'(op_start), 32'(tgt));
                chk("ep_fields", {dst_sel, src_sel}, {ins[11:8], ins[7:4]});
                d = $urandom_range(1, 17);
                ninc = $urandom_range(0, 2);
                if (ninc > d) ninc = d;
                wait_n = (d > 16) ? 16 : d;
                quiet = 1'b1;
                for (int i = 1; i <= wait_n; i++) begin
                    @(negedge clk);
                    if (op_start != 0 || fault || !busy) quiet = 1'b0;
                    pc_inc  = (i <= ninc);
                    op_done = 8'($urandom) & ~tgt;
                    if (i == d) op_done = op_done | tgt;
                end
                chk("ep_wait_quiet", 32'(quiet), 32'd1);
                pc_m = (pc_m + ninc) % 256;
                if (d > 16) begin
                    @(negedge clk);
                    pc_inc = 1'b0; op_done = '0;
                    chk("ep_timeout_fault", {fault, busy}, 2'b10);
                    chk("ep_fault_pc", 32'(imem_addr), 32'(pc_m));
                    ended = 1'b1;
                end
                gap = 3;
            end
        end
        run = 1'b0; pc_inc = 1'b0; op_done = '0;
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0; run = 1'b0; pc_inc = 1'b0; op_done = '0;
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

        // Reset state
        step(2);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_op_start", 32'(op_start), 32'h0);
        chk("rst_sel", {dst_sel, src_sel}, 8'h00);
        chk("rst_flags", {busy, halted, fault}, 3'b000);
        rst_n = 1'b1;

        // Directed vectors: first instruction outcome at the ISSUE slot (run + 3)
        vt[0] = '{16'h0320, 8'h01, 4'h3, 4'h2, 1'b0, 1'b0, 1'b1};
        vt[1] = '{16'h7AB5, 8'h80, 4'hA, 4'hB, 1'b0, 1'b0, 1'b1};
        vt[2] = '{16'h4560, 8'h10, 4'h5, 4'h6, 1'b0, 1'b0, 1'b1};
        vt[3] = '{16'hF000, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{16'hFFFF, 8'h00, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0};
        vt[5] = '{16'h9000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'h8123, 8'h00, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 7; v++) begin
            rom[0] = vt[v].ins;
            do_reset();
            run = 1'b1;
            step(3);
            chk("vec_op_start", 32'(op_start), 32'(vt[v].start));
            chk("vec_fields", {dst_sel, src_sel}, {vt[v].dst, vt[v].src});
            chk("vec_flags", {halted, fault, busy}, {vt[v].hlt, vt[v].flt, vt[v].bsy});
        end

        // MOV, pc_inc then done: next fetch from address 1
        rom[0] = 16'h0320; rom[1] = 16'h1450;
        do_reset(); run = 1'b1;
        step(3);
        chk("mov_start", 32'(op_start), 32'h01);
        @(negedge clk); chk("mov_pulse_1cyc", 32'(op_start), 32'h0); pc_inc = 1'b1;
        @(negedge clk); pc_inc = 1'b0; op_done = 8'h01;
        @(negedge clk); op_done = 8'h00;
        chk("mov_fetch_addr", 32'(imem_addr), 32'h1);
        step(2);
        chk("mov_next_start", {op_start, dst_sel, src_sel}, {8'h02, 4'h4, 4'h5});

        // HALT is terminal: pc_inc / op_done have no effect
        rom[0] = 16'hF000;
        do_reset(); run = 1'b1;
        step(1); chk("halt_fetch_not_halted", 32'(halted), 32'h0);
        step(2); chk("halt_entered", {halted, busy}, 2'b10);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_inc = 1'b1; op_done = 8'hFF; run = 1'($urandom);
            @(negedge clk);
            if (!halted || fault || busy || op_start != 0 || imem_addr != 0) ok = 1'b0;
        end
        chk("halt_sticky", 32'(ok), 32'h1);
        do_reset();
        chk("halt_cleared_by_reset", 32'(halted), 32'h0);

        // Watchdog: no done for 16 WAIT cycles
        rom[0] = 16'h0100;
        do_reset(); run = 1'b1;
        step(3);
        step(16);
        chk("wd_no_fault_at_16", {fault, busy}, 2'b01);
        @(negedge clk);
        chk("wd_fault_after_16", {fault, busy, |op_start}, 3'b100);

        // Done on the 16th WAIT cycle wins over timeout
        rom[0] = 16'h2000;
        do_reset(); run = 1'b1;
        step(3);
        step(15);
        @(negedge clk); op_done = 8'h04;
        @(negedge clk); op_done = 8'h00;
        chk("wd_done_wins", {fault, busy}, 2'b01);
        step(2);
        chk("wd_refetch_start", 32'(op_start), 32'h04);

        // Another unit's done is ignored while waiting on unit 0
        rom[0] = 16'h0000;
        do_reset(); run = 1'b1;
        step(3);
        @(negedge clk); op_done = 8'h04;
        @(negedge clk); op_done = 8'h00;
        step(2);
        chk("stray_done_ignored", {op_start, busy}, {8'h00, 1'b1});
        op_done = 8'h01;
        @(negedge clk); op_done = 8'h00;
        step(2);
        chk("stray_then_real_done", 32'(op_start), 32'h01);

        // PC wraps from FF to 0
        do_reset();
        repeat (255) begin pc_inc = 1'b1; @(negedge clk); end
        pc_inc = 1'b0;
        chk("pc_at_ff", {imem_addr, busy}, {8'hFF, 1'b0});
        pc_inc = 1'b1; @(negedge clk); pc_inc = 1'b0;
        chk("pc_wrap", 32'(imem_addr), 32'h0);

        // run dropped during WAIT: instruction completes, then IDLE
        rom[0] = 16'h0320;
        do_reset(); run = 1'b1;
        step(3);
        @(negedge clk); run = 1'b0;
        @(negedge clk); op_done = 8'h01;
        @(negedge clk); op_done = 8'h00;
        chk("rundrop_idle", 32'(busy), 32'h0);
        ok = 1'b1;
        repeat (4) begin @(negedge clk); if (busy || op_start != 0) ok = 1'b0; end
        chk("rundrop_stays_idle", 32'(ok), 32'h1);
        run = 1'b1; step(3);
        chk("rundrop_restart", 32'(op_start), 32'h01);

        // Reset pulsed during ISSUE clears asynchronously
        rom[3] = 16'h3500;
        do_reset();
        repeat (3) begin pc_inc = 1'b1; @(negedge clk); end
        pc_inc = 1'b0; run = 1'b1;
        step(3);
        chk("rstmid_issue", {op_start, imem_addr}, {8'h08, 8'h03});
        #1 rst_n = 1'b0;
        #1 chk("rstmid_async", {op_start, imem_addr, busy}, {8'h00, 8'h00, 1'b0});
        @(negedge clk); rst_n = 1'b1; run = 1'b0;

        // Randomized programs
        for (int e = 0; e < 12; e++) run_episode(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/dispatch controller directly upstream of the per-opcode execution FSMs (MOV and its siblings). Holds the program counter, reads one instruction per slot from a synchronous instruction ROM, and decodes the opcode. It then issues a one-cycle start pulse to the selected execution unit and waits for that unit's done. It advances the PC on the unit's PC-increment request and traps halt, illegal-opcode and hung-unit conditions.

## Interface
- AW, 8, PC / instruction address width
- NUM_OPS, 8, number of execution units; legal opcodes 0..NUM_OPS-1
- TIMEOUT, 16, max WAIT cycles before fault (≥2)
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- run  in  1  level enable; sampled in IDLE and at instruction completion
- imem_addr  out  AW  registered PC; ROM address
- imem_rdata  in  16  instruction; valid the cycle after imem_addr is presented
- op_start  out  NUM_OPS  one-hot start pulse, one cycle, to unit[opcode]
- op_done  in  NUM_OPS  per-unit done
- pc_inc  in  1  PC-increment request from execution units (OR of all PC_Increment)
- dst_sel  out  4  destination register field from current instruction
- src_sel  out  4  source register field from current instruction
- busy  out  1  high in any state other than IDLE/HALT/FAULT
- halted  out  1  high in HALT
- fault  out  1  high in FAULT

## Operation
- Instruction format: [15:12] opcode, [11:8] dst, [7:4] src, [3:0] reserved (ignored). Opcode 4'hF = HALT.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT, FAULT.
- IDLE: run=1 → FETCH, else stay.
- FETCH: imem_addr=pc → DECODE.
- DECODE: latch imem_rdata into IR. HALT → HALT. Opcode ≥ NUM_OPS and ≠ 4'hF → FAULT. Else → ISSUE.
- ISSUE: op_start[IR.opcode]=1 for this cycle only → WAIT. Clear timeout counter.
- WAIT: op_done[IR.opcode]=1 → FETCH if run=1, else IDLE. op_done bits of other units are ignored. The counter increments each WAIT cycle without done. At the TIMEOUT-th such cycle → FAULT. Done on that same cycle wins over the timeout.
- op_done is sampled only in WAIT; assertions in other states are ignored.
- pc_inc: in any state except HALT/FAULT, pc ← pc+1 mod 2^AW at the clock edge. If pc_inc and done occur in the same cycle, the following FETCH uses the incremented PC. PC wraps from 2^AW-1 to 0 with no flag.
- dst_sel/src_sel: driven from IR and stable from ISSUE until the next DECODE latch.
- HALT, FAULT: terminal; exited only by reset. No op_start pulses; PC frozen.
- run falling mid-instruction: the current instruction completes normally, then IDLE.
- Reset mid-operation: all state clears immediately; any in-flight op_start is dropped.
- Reset values: state=IDLE, pc=imem_addr=RESET_PC, IR=0, op_start=0, dst_sel=src_sel=0, busy=halted=fault=0, timeout counter=0.

## Timing
- run sampled high in IDLE at cycle n → FETCH n+1, DECODE n+2, ISSUE n+3 (op_start high).
- Earliest done is the first WAIT cycle (n+4) → next FETCH at n+5. Minimum instruction period is 4 cycles.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- FAULT is entered on the edge ending the TIMEOUT-th consecutive done-less WAIT cycle.

## Structure
- Package instr_seq_pkg: state enum; opcode/dst/src field bit positions; OP_HALT=4'hF; instruction width 16.
- Sub-module seq_watchdog: clear/enable/expire counter, width $clog2(TIMEOUT+1). Everything else lives in instr_sequencer.

## Test plan
- Reset release, run=1, ROM[0]=16'h0_3_2_0 (MOV dst=3 src=2) → op_start=8'h01 one cycle at cycle 3 after run; dst_sel=3, src_sel=2. Unit pulses pc_inc then done → imem_addr=1, FETCH of ROM[1].
- ROM[0]=16'hF000 → halted=1 two cycles after FETCH, busy=0, no op_start. Further pc_inc/op_done have no effect until reset.
- Opcode 4'h9 with NUM_OPS=8 → fault=1 after DECODE; no op_start.
- Unit never asserts done → fault=1 after exactly 16 WAIT cycles. Separate run with done on the 16th WAIT cycle → no fault, FETCH follows.
- op_done[2] asserted while waiting on unit 0 → ignored, stay in WAIT. Also: PC=8'hFF with pc_inc → imem_addr wraps to 0.
- run dropped during WAIT, then done → IDLE, busy=0. Reset pulsed during ISSUE → op_start=0 asynchronously, imem_addr=RESET_PC.
